// File: rtl/lc3_mem_resp.sv
// lc3_mem_resp -- LC-3 memory responder: word RAM plus optional keyboard and
// display memory-mapped I/O page.
//
// Build option: define LC3_MEM_MMIO_EN to compile in the I/O page at xFE00 and
// above (KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06). Without it, every
// address aliases into RAM and the device ports are inert.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   addr         word address from MAR
//   data_in      write data from MDR
//   data_out     combinational read data of the addressed location
//   memWE        one-cycle write strobe
//   ldMAR        MAR load; a read strobe follows one cycle later
//   kbd_data     keyboard character
//   kbd_valid    keyboard character offered
//   kbd_ready    responder can accept a keyboard character
//   dsp_data     display character
//   dsp_valid    display character pending
//   dsp_ready    display sink accepts the pending character
//
// Display state machine:
//   state   | meaning
//   DS_IDLE | no character pending, DDR writes accepted (ds_ready=1)
//   DS_PEND | character pending on dsp_data, waiting for dsp_ready
module lc3_mem_resp #(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   input  logic        memWE,
   input  logic        ldMAR,
   input  logic [7:0]  kbd_data,
   input  logic        kbd_valid,
   output logic        kbd_ready,
   output logic [7:0]  dsp_data,
   output logic        dsp_valid,
   input  logic        dsp_ready
);

   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;

   logic [15:0]       mem [0:(1 << ADDR_W) - 1];
   logic [ADDR_W-1:0] ram_idx;
   logic              io_page;
   logic [15:0]       ram_rd;

   assign ram_idx = addr[ADDR_W-1:0];
   assign ram_rd  = mem[ram_idx];

   // RAM contents survive reset on purpose; only the device state is cleared.
   always_ff @(posedge clk) begin
      if (memWE && !io_page) begin
         mem[ram_idx] <= data_in;
      end
   end

`ifdef LC3_MEM_MMIO_EN

   typedef enum logic {
      DS_IDLE = 1'b0,
      DS_PEND = 1'b1
   } ds_state_t;

   ds_state_t  ds_state, ds_state_next;
   logic [7:0] dsp_data_q, dsp_data_next;
   logic       ds_ovr_q, ds_ovr_next;
   logic       ds_ready;
   logic       ddr_wr;

   logic       ldmar_q;
   logic       rd_stb;
   logic       kb_full;
   logic [7:0] kb_char;
   logic       kb_accept;
   logic       kbdr_clr;

   // xFE00..xFFFF
   assign io_page = (addr[15:9] == 7'h7F);

   assign rd_stb = ldmar_q && !memWE;

   always_ff @(posedge clk) begin
      if (rst) begin
         ldmar_q <= 1'b0;
      end else begin
         ldmar_q <= ldMAR;
      end
   end

   assign kbd_ready = !kb_full;
   assign kb_accept = kbd_valid && !kb_full;
   assign kbdr_clr  = rd_stb && (addr == KBDR_ADDR);

   // A new character accepted in the same cycle as a KBDR read must not be
   // lost, so the accept takes priority over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         kb_full <= 1'b0;
         kb_char <= 8'h00;
      end else if (kb_accept) begin
         kb_full <= 1'b1;
         kb_char <= kbd_data;
      end else if (kbdr_clr) begin
         kb_full <= 1'b0;
      end
   end

   assign ddr_wr = memWE && (addr == DDR_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         ds_state   <= DS_IDLE;
         dsp_data_q <= 8'h00;
         ds_ovr_q   <= 1'b0;
      end else begin
         ds_state   <= ds_state_next;
         dsp_data_q <= dsp_data_next;
         ds_ovr_q   <= ds_ovr_next;
      end
   end

   // A handshake completing in the same cycle as a DDR write frees the slot
   // first, so the write is taken and the new character stays pending.
   always_comb begin
      ds_state_next = ds_state;
      dsp_data_next = dsp_data_q;
      ds_ovr_next   = ds_ovr_q;
      case (ds_state)
         DS_IDLE: begin
            if (ddr_wr) begin
               ds_state_next = DS_PEND;
               dsp_data_next = data_in[7:0];
            end
         end
         DS_PEND: begin
            if (dsp_ready && ddr_wr) begin
               dsp_data_next = data_in[7:0];
            end else if (dsp_ready) begin
               ds_state_next = DS_IDLE;
            end else if (ddr_wr) begin
               ds_ovr_next = 1'b1;
            end
         end
         default: ds_state_next = DS_IDLE;
      endcase
   end

   assign ds_ready  = (ds_state == DS_IDLE);
   assign dsp_valid = (ds_state == DS_PEND);
   assign dsp_data  = dsp_data_q;

   always_comb begin
      data_out = ram_rd;
      if (io_page) begin
         case (addr)
            KBSR_ADDR: data_out = {kb_full, 15'b0};
            KBDR_ADDR: data_out = {8'b0, kb_char};
            DSR_ADDR:  data_out = {ds_ready, ds_ovr_q, 14'b0};
            DDR_ADDR:  data_out = {8'b0, dsp_data_q};
            default:   data_out = 16'h0000;
         endcase
      end
   end

`else

   logic unused_inputs;

   assign io_page   = 1'b0;
   assign data_out  = ram_rd;
   assign kbd_ready = 1'b0;
   assign dsp_valid = 1'b0;
   assign dsp_data  = 8'h00;

   assign unused_inputs = ^{rst, ldMAR, kbd_data, kbd_valid, dsp_ready,
                            addr[15:ADDR_W]};

`endif

endmodule

// File: tb/tb_lc3_mem_resp.sv
// tb_lc3_mem_resp -- directed testbench for lc3_mem_resp (ADDR_W=10).
// Selects the I/O-page scenarios or the RAM-only scenarios according to
// whether LC3_MEM_MMIO_EN is defined for the build.
module tb_lc3_mem_resp;

   logic        clk;
   logic        rst;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        memWE;
   logic        ldMAR;
   logic [7:0]  kbd_data;
   logic        kbd_valid;
   logic        kbd_ready;
   logic [7:0]  dsp_data;
   logic        dsp_valid;
   logic        dsp_ready;

   int n_checks = 0;
   int n_fail   = 0;

   lc3_mem_resp #(.ADDR_W(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .data_in   (data_in),
      .data_out  (data_out),
      .memWE     (memWE),
      .ldMAR     (ldMAR),
      .kbd_data  (kbd_data),
      .kbd_valid (kbd_valid),
      .kbd_ready (kbd_ready),
      .dsp_data  (dsp_data),
      .dsp_valid (dsp_valid),
      .dsp_ready (dsp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      addr    = a;
      data_in = d;
      memWE   = 1'b1;
      cyc();
      memWE   = 1'b0;
   endtask

   // MAR load cycle; the following cycle carries the read strobe.
   task automatic load_mar(input logic [15:0] a);
      ldMAR = 1'b1;
      cyc();
      ldMAR = 1'b0;
      addr  = a;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      n_checks++;
      if (dsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dsp_valid: got %b expected 0", dsp_valid);
      end
      n_checks++;
      if (dsp_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_dsp_data: got %h expected 00", dsp_data);
      end
`ifdef LC3_MEM_MMIO_EN
      n_checks++;
      if (kbd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_kbd_ready: got %b expected 1", kbd_ready);
      end
      addr = 16'hFE04;
      #1;
      n_checks++;
      if (data_out !== 16'h8000) begin
         n_fail++;
         $display("FAIL reset_dsr: got %h expected 8000", data_out);
      end
      addr = 16'hFE00;
      #1;
      n_checks++;
      if (data_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_kbsr: got %h expected 0000", data_out);
      end
`else
      n_checks++;
      if (kbd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_kbd_ready_tied: got %b expected 0", kbd_ready);
      end
`endif
   endtask

   task automatic test_ram();
      wr(16'h0005, 16'h1234);
      load_mar(16'h0005);
      n_checks++;
      if (data_out !== 16'h1234) begin
         n_fail++;
         $display("FAIL ram_read_0005: got %h expected 1234", data_out);
      end
      load_mar(16'h0405);
      n_checks++;
      if (data_out !== 16'h1234) begin
         n_fail++;
         $display("FAIL ram_alias_0405: got %h expected 1234", data_out);
      end
      // Write then immediate read of the same address in the next cycle.
      wr(16'h03FF, 16'hA5C3);
      addr = 16'h03FF;
      #1;
      n_checks++;
      if (data_out !== 16'hA5C3) begin
         n_fail++;
         $display("FAIL ram_wr_then_rd_03ff: got %h expected a5c3", data_out);
      end
      // Aliased write lands on the base index.
      wr(16'h8010, 16'h0F0F);
      addr = 16'h0010;
      #1;
      n_checks++;
      if (data_out !== 16'h0F0F) begin
         n_fail++;
         $display("FAIL ram_alias_write_0010: got %h expected 0f0f", data_out);
      end
      addr = 16'h0005;
      #1;
      n_checks++;
      if (data_out !== 16'h1234) begin
         n_fail++;
         $display("FAIL ram_untouched_0005: got %h expected 1234", data_out);
      end
   endtask

`ifdef LC3_MEM_MMIO_EN

   task automatic test_keyboard();
      kbd_data  = 8'h41;
      kbd_valid = 1'b1;
      cyc();
      kbd_valid = 1'b0;
      n_checks++;
      if (kbd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL kbd_ready_after_accept: got %b expected 0", kbd_ready);
      end
      addr = 16'hFE00;
      #1;
      n_checks++;
      if (data_out !== 16'h8000) begin
         n_fail++;
         $display("FAIL kbsr_full: got %h expected 8000", data_out);
      end
      // A write to KBSR is ignored.
      wr(16'hFE00, 16'h0000);
      n_checks++;
      if (data_out !== 16'h8000) begin
         n_fail++;
         $display("FAIL kbsr_write_ignored: got %h expected 8000", data_out);
      end
      load_mar(16'hFE02);
      n_checks++;
      if (data_out !== 16'h0041) begin
         n_fail++;
         $display("FAIL kbdr_read: got %h expected 0041", data_out);
      end
      cyc();
      addr = 16'hFE00;
      #1;
      n_checks++;
      if (data_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL kbsr_cleared: got %h expected 0000", data_out);
      end
      n_checks++;
      if (kbd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL kbd_ready_after_read: got %b expected 1", kbd_ready);
      end
   endtask

   task automatic test_kbd_collision();
      // KBDR read strobe and a new accept in the same cycle: the set wins.
      ldMAR = 1'b1;
      cyc();
      ldMAR     = 1'b0;
      addr      = 16'hFE02;
      kbd_data  = 8'h5A;
      kbd_valid = 1'b1;
      cyc();
      kbd_valid = 1'b0;
      #1;
      n_checks++;
      if (kbd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_kbd_ready: got %b expected 0", kbd_ready);
      end
      n_checks++;
      if (data_out !== 16'h005A) begin
         n_fail++;
         $display("FAIL collide_kbdr: got %h expected 005a", data_out);
      end
   endtask

   task automatic test_display();
      wr(16'h0206, 16'hBEEF);
      dsp_ready = 1'b0;
      wr(16'hFE06, 16'h0048);
      repeat (5) cyc();
      addr = 16'hFE04;
      #1;
      n_checks++;
      if (dsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL dsp_valid_pending: got %b expected 1", dsp_valid);
      end
      n_checks++;
      if (dsp_data !== 8'h48) begin
         n_fail++;
         $display("FAIL dsp_data_pending: got %h expected 48", dsp_data);
      end
      n_checks++;
      if (data_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL dsr_busy: got %h expected 0000", data_out);
      end
      dsp_ready = 1'b1;
      cyc();
      dsp_ready = 1'b0;
      #1;
      n_checks++;
      if (data_out !== 16'h8000) begin
         n_fail++;
         $display("FAIL dsr_ready_after_hs: got %h expected 8000", data_out);
      end
      n_checks++;
      if (dsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL dsp_valid_after_hs: got %b expected 0", dsp_valid);
      end
      addr = 16'h0206;
      #1;
      n_checks++;
      if (data_out !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL ram_not_written_by_io: got %h expected beef", data_out);
      end
      addr = 16'hFE08;
      #1;
      n_checks++;
      if (data_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL unmapped_io_read: got %h expected 0000", data_out);
      end
   endtask

   task automatic test_display_overrun();
      wr(16'hFE06, 16'h0048);
      wr(16'hFE06, 16'h0049);
      addr = 16'hFE04;
      #1;
      n_checks++;
      if (dsp_data !== 8'h48) begin
         n_fail++;
         $display("FAIL ovr_dsp_data_held: got %h expected 48", dsp_data);
      end
      n_checks++;
      if (data_out !== 16'h4000) begin
         n_fail++;
         $display("FAIL ovr_dsr: got %h expected 4000", data_out);
      end
   endtask

   task automatic test_back_to_back();
      // Completion and a DDR write in the same cycle: new char stays pending.
      dsp_ready = 1'b1;
      wr(16'hFE06, 16'h004A);
      dsp_ready = 1'b0;
      #1;
      n_checks++;
      if (dsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_dsp_valid: got %b expected 1", dsp_valid);
      end
      n_checks++;
      if (dsp_data !== 8'h4A) begin
         n_fail++;
         $display("FAIL b2b_dsp_data: got %h expected 4a", dsp_data);
      end
   endtask

   task automatic test_reset_mid();
      // Display has x4A pending and keyboard holds x5A; reset also beats a new offer.
      n_checks++;
      if (kbd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_rst_kbd_full: got kbd_ready %b expected 0", kbd_ready);
      end
      rst       = 1'b1;
      kbd_valid = 1'b1;
      kbd_data  = 8'h77;
      addr      = 16'hFE06;
      data_in   = 16'h0055;
      memWE     = 1'b1;
      cyc();
      rst       = 1'b0;
      kbd_valid = 1'b0;
      memWE     = 1'b0;
      addr      = 16'hFE04;
      #1;
      n_checks++;
      if (dsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_dsp_valid: got %b expected 0", dsp_valid);
      end
      n_checks++;
      if (kbd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_kbd_ready: got %b expected 1", kbd_ready);
      end
      n_checks++;
      if (data_out !== 16'h8000) begin
         n_fail++;
         $display("FAIL rst_dsr: got %h expected 8000", data_out);
      end
      n_checks++;
      if (dsp_data !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_dsp_data: got %h expected 00", dsp_data);
      end
      addr = 16'h0005;
      #1;
      n_checks++;
      if (data_out !== 16'h1234) begin
         n_fail++;
         $display("FAIL rst_ram_kept: got %h expected 1234", data_out);
      end
   endtask

`else

   task automatic test_no_mmio();
      // The I/O page aliases into RAM: xFE06 maps to index x206.
      kbd_valid = 1'b1;
      kbd_data  = 8'h41;
      dsp_ready = 1'b1;
      wr(16'hFE06, 16'h0048);
      addr = 16'h0206;
      #1;
      n_checks++;
      if (data_out !== 16'h0048) begin
         n_fail++;
         $display("FAIL nommio_alias_0206: got %h expected 0048", data_out);
      end
      addr = 16'hFE06;
      #1;
      n_checks++;
      if (data_out !== 16'h0048) begin
         n_fail++;
         $display("FAIL nommio_read_fe06: got %h expected 0048", data_out);
      end
      wr(16'hFE00, 16'h7777);
      addr = 16'h0200;
      #1;
      n_checks++;
      if (data_out !== 16'h7777) begin
         n_fail++;
         $display("FAIL nommio_alias_0200: got %h expected 7777", data_out);
      end
      n_checks++;
      if (kbd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL nommio_kbd_ready: got %b expected 0", kbd_ready);
      end
      n_checks++;
      if (dsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL nommio_dsp_valid: got %b expected 0", dsp_valid);
      end
      n_checks++;
      if (dsp_data !== 8'h00) begin
         n_fail++;
         $display("FAIL nommio_dsp_data: got %h expected 00", dsp_data);
      end
      kbd_valid = 1'b0;
      dsp_ready = 1'b0;
      rst = 1'b1;
      cyc();
      rst  = 1'b0;
      addr = 16'h0005;
      #1;
      n_checks++;
      if (data_out !== 16'h1234) begin
         n_fail++;
         $display("FAIL nommio_rst_ram_kept: got %h expected 1234", data_out);
      end
   endtask

`endif

   initial begin
      rst       = 1'b1;
      addr      = 16'h0000;
      data_in   = 16'h0000;
      memWE     = 1'b0;
      ldMAR     = 1'b0;
      kbd_data  = 8'h00;
      kbd_valid = 1'b0;
      dsp_ready = 1'b0;

      test_reset();
      test_ram();
`ifdef LC3_MEM_MMIO_EN
      test_keyboard();
      test_kbd_collision();
      test_display();
      test_display_overrun();
      test_back_to_back();
      test_reset_mid();
`else
      test_no_mmio();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
